svi_force_combiner: RTL

Parametrised N-channel combiner with per-channel force/release override and time-multiplexed reduction mode. It sits between a shared interface bundle and its consumers. Each channel holds a registered value that one writer updates. A channel can be forced to an override value, with release semantics that retain the forced value until the next write. All effective channel values are reduced by OR, AND or XOR into one registered output, and an internal period counter can alternate the reduction mode automatically.

---
 rtl/svi_force_combiner.sv | 82 ++++++++
 1 files changed

// File: rtl/svi_force_combiner.sv
// svi_force_combiner: N-channel registered combiner with force/release override and
// OR/AND/XOR reduction, optionally alternating OR/AND on a free-running period counter.
module svi_force_combiner #(
  parameter int N_CHAN = 2,
  parameter int WIDTH  = 1,
  parameter int PERIOD = 16
) (
  input  logic                    i_sclk,
  input  logic                    i_arst_n,
  input  logic [N_CHAN-1:0]       i_wr_valid,
  input  logic [N_CHAN*WIDTH-1:0] i_wr_data,
  input  logic [N_CHAN-1:0]       i_force_set,
  input  logic [N_CHAN-1:0]       i_force_rel,
  input  logic [N_CHAN*WIDTH-1:0] i_force_data,
  input  logic                    i_mode_auto,
  input  logic [1:0]              i_mode,
  output logic [WIDTH-1:0]        o_combined,
  output logic [1:0]              o_sel_mode,
  output logic [N_CHAN-1:0]       o_forced,
  output logic                    o_wrap
);
  localparam int CW = $clog2(PERIOD);
  logic [N_CHAN-1:0][WIDTH-1:0] wr_data, frc_data, chan_q, chan_d, frc_q, frc_d, eff;
  logic [N_CHAN-1:0]            forced_q, forced_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         phase_q, wrap, wrap_q;
  logic [WIDTH-1:0]             red_or, red_and, red_xor, comb_q, comb_d;
  logic [1:0]                   sel_mode, sel_q;
  assign wr_data  = i_wr_data;
  assign frc_data = i_force_data;
  always_comb begin
    chan_d   = chan_q;
    frc_d    = frc_q;
    forced_d = forced_q;
    eff      = chan_q;
    for (int c = 0; c < N_CHAN; c++) begin
      eff[c]      = forced_q[c] ? frc_q[c] : chan_q[c];
      // a release hands the override value back to the channel; a same-cycle write wins
      chan_d[c]   = i_wr_valid[c] ? wr_data[c]
                  : (i_force_rel[c] && forced_q[c] && !i_force_set[c]) ? frc_q[c] : chan_q[c];
      frc_d[c]    = i_force_set[c] ? frc_data[c] : frc_q[c];
      forced_d[c] = i_force_set[c] ? 1'b1 : i_force_rel[c] ? 1'b0 : forced_q[c];
    end
    red_or  = eff[0];
    red_and = eff[0];
    red_xor = eff[0];
    for (int c = 1; c < N_CHAN; c++) begin
      red_or  = red_or | eff[c];
      red_and = red_and & eff[c];
      red_xor = red_xor ^ eff[c];
    end
    sel_mode = i_mode_auto ? {1'b0, phase_q} : (i_mode == 2'd3 ? 2'd0 : i_mode);
    comb_d   = sel_mode == 2'd1 ? red_and : sel_mode == 2'd2 ? red_xor : red_or;
    wrap     = cnt_q == CW'(PERIOD - 1);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge i_sclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      chan_q   <= '0;
      frc_q    <= '0;
      forced_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      wrap_q   <= 1'b0;
      comb_q   <= '0;
      sel_q    <= 2'd0;
    end else begin
      chan_q   <= chan_d;
      frc_q    <= frc_d;
      forced_q <= forced_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_q ^ wrap;
      wrap_q   <= wrap;
      comb_q   <= comb_d;
      sel_q    <= sel_mode;
    end
  end
  assign o_combined = comb_q;
  assign o_sel_mode = sel_q;
  assign o_forced   = forced_q;
  assign o_wrap     = wrap_q;
endmodule
